// File: rtl/fft_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package  : fft_pkg                                                   |
// | Purpose  : Shared types and defaults for the FFT sample-RAM arbiter. |
// |            Holds the address/data width defaults, the requester      |
// |            source encoding and the read-return owner tag.            |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package fft_pkg;

   localparam int c_aw_default = 16;   // matches afft8 addr
   localparam int c_dw_default = 32;   // matches afft8 data_i/data_o

   // Which requester issued a RAM read
   typedef enum logic {
      SRC_FFT  = 1'b0,
      SRC_HOST = 1'b1
   } src_e;

   // Owner tag carried alongside each RAM access until its read data returns
   typedef struct packed {
      logic valid;
      src_e src;
   } rd_tag_t;

endpackage : fft_pkg
`default_nettype wire

// File: rtl/fft_mem_arb_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Interface : fft_mem_arb_if                                           |
// | Purpose   : One requester's access port onto the shared sample RAM.  |
// |             master - the requester (afft8 engine or host bus)        |
// |             slave  - the arbiter                                     |
// | Signals   : req/we/addr/wdata  request side (master -> slave)        |
// |             gnt                access accepted this cycle (comb.)    |
// |             rdata/rvalid       read return, one-cycle rvalid pulse   |
// | Revision  : 1.0 - initial release                                    |
// +----------------------------------------------------------------------+
interface fft_mem_arb_if
   import fft_pkg::*;
#(
   parameter int AW = c_aw_default,
   parameter int DW = c_dw_default
) ();

   logic          req;
   logic          we;
   logic [AW-1:0] addr;
   logic [DW-1:0] wdata;
   logic          gnt;
   logic [DW-1:0] rdata;
   logic          rvalid;

   modport master (
      output req, we, addr, wdata,
      input  gnt, rdata, rvalid
   );

   modport slave (
      input  req, we, addr, wdata,
      output gnt, rdata, rvalid
   );

endinterface : fft_mem_arb_if
`default_nettype wire

// File: rtl/rd_tag_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : rd_tag_pipe                                               |
// | Purpose  : RD_LAT-deep shift register of read owner tags, cleared    |
// |            asynchronously so in-flight reads are dropped on reset.   |
// | Ports    : clk, rst_n  clock, async active-low clear                 |
// |            i_tag       tag entering alongside the RAM strobe         |
// |            o_tag       tag aligned with valid RAM read data          |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module rd_tag_pipe
   import fft_pkg::*;
#(
   parameter int RD_LAT = 1
) (
   input  logic    clk,
   input  logic    rst_n,
   input  rd_tag_t i_tag,
   output rd_tag_t o_tag
);

   rd_tag_t r_stage [RD_LAT];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < RD_LAT; i++) begin
            r_stage[i] <= '0;
         end
      end else begin
         r_stage[0] <= i_tag;
         for (int i = 1; i < RD_LAT; i++) begin
            r_stage[i] <= r_stage[i-1];
         end
      end
   end

   assign o_tag = r_stage[RD_LAT-1];

endmodule : rd_tag_pipe
`default_nettype wire

// File: rtl/fft_mem_arb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : fft_mem_arb                                               |
// | Purpose  : Shares one single-port synchronous-read sample RAM        |
// |            between the afft8 engine and the host bus. One access     |
// |            per cycle; FFT has priority, a starvation counter gives   |
// |            the host a slot unless the FFT holds fft_lock.            |
// | Ports    : clk, rst_n        clock, async active-low reset           |
// |            fft_lock          FFT ownership, blocks host override     |
// |            fft_if / host_if  requester ports (slave modport)         |
// |            mem_en/we/addr/wdata  registered RAM port                 |
// |            mem_rdata         RAM read data, RD_LAT after mem_en      |
// | Timing   : grant in T, RAM port in T+1, rvalid in T+2+RD_LAT         |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module fft_mem_arb
   import fft_pkg::*;
#(
   parameter int AW       = c_aw_default,
   parameter int DW       = c_dw_default,
   parameter int RD_LAT   = 1,    // 1..4
   parameter int MAX_WAIT = 8     // 1..255
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          fft_lock,
   fft_mem_arb_if.slave  fft_if,
   fft_mem_arb_if.slave  host_if,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   localparam logic [7:0] c_max_wait = 8'(MAX_WAIT);

   logic [7:0]    r_wait_cnt;
   logic          w_fft_gnt;
   logic          w_host_gnt;
   logic          w_accept;
   logic          w_sel_we;
   logic [AW-1:0] w_sel_addr;
   logic [DW-1:0] w_sel_wdata;
   rd_tag_t       w_tag_in;
   rd_tag_t       r_tag;
   rd_tag_t       w_tag_out;

   logic          r_mem_en;
   logic          r_mem_we;
   logic [AW-1:0] r_mem_addr;
   logic [DW-1:0] r_mem_wdata;
   logic          r_fft_rvalid;
   logic          r_host_rvalid;
   logic [DW-1:0] r_fft_rdata;
   logic [DW-1:0] r_host_rdata;

   // Grant: FFT wins unless the host is also requesting, the FFT is
   // unlocked and the host has already been refused MAX_WAIT times.
   always_comb begin
      w_fft_gnt   = fft_if.req &
                    (~host_if.req | fft_lock | (r_wait_cnt < c_max_wait));
      w_host_gnt  = host_if.req & ~w_fft_gnt;
      w_accept    = w_fft_gnt | w_host_gnt;
      w_sel_we    = w_host_gnt ? host_if.we    : fft_if.we;
      w_sel_addr  = w_host_gnt ? host_if.addr  : fft_if.addr;
      w_sel_wdata = w_host_gnt ? host_if.wdata : fft_if.wdata;
      w_tag_in.valid = w_accept & ~w_sel_we;
      w_tag_in.src   = w_host_gnt ? SRC_HOST : SRC_FFT;
   end

   // Consecutive refused host cycles, saturating
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wait_cnt <= '0;
      end else if (host_if.req & ~w_host_gnt) begin
         if (r_wait_cnt != 8'hFF) begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
         end
      end else begin
         r_wait_cnt <= '0;
      end
   end

   // RAM port register; addr/wdata hold when idle to avoid needless toggling.
   // r_tag sits in the same stage as mem_en so the tag pipe lines up with
   // mem_rdata exactly RD_LAT cycles later.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mem_en    <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_tag       <= '0;
      end else begin
         r_mem_en <= w_accept;
         r_mem_we <= w_accept & w_sel_we;
         r_tag    <= w_tag_in;
         if (w_accept) begin
            r_mem_addr  <= w_sel_addr;
            r_mem_wdata <= w_sel_wdata;
         end
      end
   end

   rd_tag_pipe #(
      .RD_LAT (RD_LAT)
   ) u_tag_pipe (
      .clk   (clk),
      .rst_n (rst_n),
      .i_tag (r_tag),
      .o_tag (w_tag_out)
   );

   // Read return: route mem_rdata to the tagged owner; the other holds.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fft_rvalid  <= 1'b0;
         r_host_rvalid <= 1'b0;
         r_fft_rdata   <= '0;
         r_host_rdata  <= '0;
      end else begin
         r_fft_rvalid  <= w_tag_out.valid & (w_tag_out.src == SRC_FFT);
         r_host_rvalid <= w_tag_out.valid & (w_tag_out.src == SRC_HOST);
         if (w_tag_out.valid & (w_tag_out.src == SRC_FFT)) begin
            r_fft_rdata <= mem_rdata;
         end
         if (w_tag_out.valid & (w_tag_out.src == SRC_HOST)) begin
            r_host_rdata <= mem_rdata;
         end
      end
   end

   assign fft_if.gnt     = w_fft_gnt;
   assign fft_if.rdata   = r_fft_rdata;
   assign fft_if.rvalid  = r_fft_rvalid;
   assign host_if.gnt    = w_host_gnt;
   assign host_if.rdata  = r_host_rdata;
   assign host_if.rvalid = r_host_rvalid;

   assign mem_en    = r_mem_en;
   assign mem_we    = r_mem_we;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;

endmodule : fft_mem_arb
`default_nettype wire

// File: tb/tb_fft_mem_arb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_fft_mem_arb                                            |
// | Purpose  : Directed self-checking bench for fft_mem_arb. Three DUTs  |
// |            (RD_LAT = 1, 2, 4) share one stimulus; each has its own   |
// |            RAM model. Unwritten RAM words read as 0xC0DE_0000|addr.  |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_fft_mem_arb;
   import fft_pkg::*;

   localparam int AW   = 16;
   localparam int DW   = 32;
   localparam int NDUT = 3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          fft_lock = 1'b0;
   logic          fft_req = 1'b0, fft_we = 1'b0;
   logic          host_req = 1'b0, host_we = 1'b0;
   logic [AW-1:0] fft_addr = '0, host_addr = '0;
   logic [DW-1:0] fft_wdata = '0, host_wdata = '0;

   logic [NDUT-1:0] fft_gnt_v, host_gnt_v, fft_rvalid_v, host_rvalid_v;
   logic [NDUT-1:0] mem_en_v, mem_we_v;
   logic [DW-1:0]   fft_rdata_a [NDUT];
   logic [DW-1:0]   host_rdata_a [NDUT];
   logic [DW-1:0]   mem_wdata_a [NDUT];
   logic [AW-1:0]   mem_addr_a [NDUT];

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   for (genvar k = 0; k < NDUT; k++) begin : g_dut
      localparam int L = (k == 0) ? 1 : ((k == 1) ? 2 : 4);

      fft_mem_arb_if #(.AW(AW), .DW(DW)) fft_bus ();
      fft_mem_arb_if #(.AW(AW), .DW(DW)) host_bus ();

      logic          mem_en, mem_we;
      logic [AW-1:0] mem_addr;
      logic [DW-1:0] mem_wdata, mem_rdata;
      logic [DW-1:0] ram [256];
      logic [255:0]  written = '0;
      logic [DW-1:0] rd_pipe [L];

      assign fft_bus.req    = fft_req;
      assign fft_bus.we     = fft_we;
      assign fft_bus.addr   = fft_addr;
      assign fft_bus.wdata  = fft_wdata;
      assign host_bus.req   = host_req;
      assign host_bus.we    = host_we;
      assign host_bus.addr  = host_addr;
      assign host_bus.wdata = host_wdata;

      assign fft_gnt_v[k]     = fft_bus.gnt;
      assign host_gnt_v[k]    = host_bus.gnt;
      assign fft_rvalid_v[k]  = fft_bus.rvalid;
      assign host_rvalid_v[k] = host_bus.rvalid;
      assign fft_rdata_a[k]   = fft_bus.rdata;
      assign host_rdata_a[k]  = host_bus.rdata;
      assign mem_en_v[k]      = mem_en;
      assign mem_we_v[k]      = mem_we;
      assign mem_addr_a[k]    = mem_addr;
      assign mem_wdata_a[k]   = mem_wdata;

      // Synchronous-read RAM, data valid L cycles after mem_en
      always @(posedge clk) begin
         if (mem_en && mem_we) begin
            ram[mem_addr[7:0]]     <= mem_wdata;
            written[mem_addr[7:0]] <= 1'b1;
         end
         if (mem_en && !mem_we)
            rd_pipe[0] <= written[mem_addr[7:0]] ? ram[mem_addr[7:0]]
                                                 : (32'hC0DE_0000 | 32'(mem_addr));
         else
            rd_pipe[0] <= 32'hDEAD_BEEF;
         for (int i = 1; i < L; i++) rd_pipe[i] <= rd_pipe[i-1];
      end
      assign mem_rdata = rd_pipe[L-1];

      fft_mem_arb #(
         .AW(AW), .DW(DW), .RD_LAT(L), .MAX_WAIT(8)
      ) u_dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .fft_lock  (fft_lock),
         .fft_if    (fft_bus),
         .host_if   (host_bus),
         .mem_en    (mem_en),
         .mem_we    (mem_we),
         .mem_addr  (mem_addr),
         .mem_wdata (mem_wdata),
         .mem_rdata (mem_rdata)
      );
   end

   function automatic int lat_of(input int d);
      return (d == 0) ? 1 : ((d == 1) ? 2 : 4);
   endfunction

   task automatic idle_inputs();
      fft_req = 1'b0; fft_we = 1'b0; host_req = 1'b0; host_we = 1'b0; fft_lock = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      for (int d = 0; d < NDUT; d++) begin
         checks++;
         if ({mem_en_v[d], mem_we_v[d], fft_rvalid_v[d], host_rvalid_v[d],
              fft_gnt_v[d], host_gnt_v[d]} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl dut%0d: got en=%b we=%b frv=%b hrv=%b fg=%b hg=%b, expected all 0",
                     d, mem_en_v[d], mem_we_v[d], fft_rvalid_v[d], host_rvalid_v[d],
                     fft_gnt_v[d], host_gnt_v[d]);
         end
         checks++;
         if (mem_addr_a[d] !== '0 || mem_wdata_a[d] !== '0) begin
            errors++;
            $display("FAIL reset_mem dut%0d: got addr=%h wdata=%h, expected 0", d,
                     mem_addr_a[d], mem_wdata_a[d]);
         end
         checks++;
         if (fft_rdata_a[d] !== '0 || host_rdata_a[d] !== '0) begin
            errors++;
            $display("FAIL reset_rdata dut%0d: got fft=%h host=%h, expected 0", d,
                     fft_rdata_a[d], host_rdata_a[d]);
         end
      end
      // Issue a read, then reset while it is still in flight
      rst_n = 1'b1;
      @(negedge clk);
      fft_req = 1'b1; fft_we = 1'b0; fft_addr = 16'h0005;
      @(negedge clk);
      fft_req = 1'b0;
      #1;
      checks++;
      if (mem_en_v !== 3'b111) begin
         errors++;
         $display("FAIL reset_inflight_en: got %b, expected 111", mem_en_v);
      end
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if (mem_en_v !== 3'b000 || mem_addr_a[0] !== '0) begin
         errors++;
         $display("FAIL reset_async: got en=%b addr=%h, expected en=000 addr=0",
                  mem_en_v, mem_addr_a[0]);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         #1;
         checks++;
         if ((fft_rvalid_v | host_rvalid_v) !== 3'b000) begin
            errors++;
            $display("FAIL reset_no_rvalid cyc%0d: got fft=%b host=%b, expected 000", c,
                     fft_rvalid_v, host_rvalid_v);
         end
      end
   endtask

   // Write 0x3 then read it back on the next grant (read-after-write)
   task automatic test_fft_only();
      @(negedge clk);
      fft_req = 1'b1; fft_we = 1'b1; fft_addr = 16'h0003; fft_wdata = 32'h1234_5678;
      #1;
      checks++;
      if (fft_gnt_v !== 3'b111 || host_gnt_v !== 3'b000) begin
         errors++;
         $display("FAIL fft_wr_gnt: got fft=%b host=%b, expected 111/000", fft_gnt_v, host_gnt_v);
      end
      @(negedge clk);
      #1;
      for (int d = 0; d < NDUT; d++) begin
         checks++;
         if (mem_en_v[d] !== 1'b1 || mem_we_v[d] !== 1'b1 ||
             mem_addr_a[d] !== 16'h0003 || mem_wdata_a[d] !== 32'h1234_5678) begin
            errors++;
            $display("FAIL fft_wr_port dut%0d: got en=%b we=%b addr=%h wdata=%h, expected 1 1 0003 12345678",
                     d, mem_en_v[d], mem_we_v[d], mem_addr_a[d], mem_wdata_a[d]);
         end
      end
      fft_we = 1'b0;   // read negedge = k 0
      #1;
      checks++;
      if (fft_gnt_v !== 3'b111) begin
         errors++;
         $display("FAIL fft_rd_gnt: got %b, expected 111", fft_gnt_v);
      end
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (k == 1) fft_req = 1'b0;
         #1;
         if (k == 1) begin
            checks++;
            if (mem_en_v !== 3'b111 || mem_we_v !== 3'b000 || mem_addr_a[2] !== 16'h0003) begin
               errors++;
               $display("FAIL fft_rd_port: got en=%b we=%b addr=%h, expected 111 000 0003",
                        mem_en_v, mem_we_v, mem_addr_a[2]);
            end
         end
         if (k == 2) begin
            checks++;
            if (mem_en_v !== 3'b000 || mem_we_v !== 3'b000 || mem_addr_a[1] !== 16'h0003) begin
               errors++;
               $display("FAIL fft_idle_port: got en=%b we=%b addr=%h, expected 000 000 0003 (held)",
                        mem_en_v, mem_we_v, mem_addr_a[1]);
            end
         end
         for (int d = 0; d < NDUT; d++) begin
            logic exp_v;
            exp_v = (k == 2 + lat_of(d));
            checks++;
            if (fft_rvalid_v[d] !== exp_v || host_rvalid_v[d] !== 1'b0) begin
               errors++;
               $display("FAIL fft_rvalid dut%0d k%0d: got fft=%b host=%b, expected fft=%b host=0",
                        d, k, fft_rvalid_v[d], host_rvalid_v[d], exp_v);
            end
            if (exp_v) begin
               checks++;
               if (fft_rdata_a[d] !== 32'h1234_5678) begin
                  errors++;
                  $display("FAIL fft_rdata dut%0d: got %h, expected 12345678", d, fft_rdata_a[d]);
               end
            end
         end
      end
   endtask

   // Continuous contention, unlocked, MAX_WAIT=8: 8 FFT grants then 1 host
   task automatic test_contention_unlocked();
      @(negedge clk);
      fft_lock = 1'b0;
      fft_req = 1'b1; fft_we = 1'b0; fft_addr = 16'h0040;
      host_req = 1'b1; host_we = 1'b0; host_addr = 16'h0041;
      for (int c = 0; c < 18; c++) begin
         logic exp_h;
         exp_h = (c == 8) || (c == 17);
         #1;
         checks++;
         if (fft_gnt_v !== {3{~exp_h}} || host_gnt_v !== {3{exp_h}}) begin
            errors++;
            $display("FAIL contention_unlocked cyc%0d: got fft=%b host=%b, expected host_gnt=%b",
                     c, fft_gnt_v, host_gnt_v, exp_h);
         end
         @(negedge clk);
      end
      idle_inputs();
      repeat (8) @(negedge clk);
   endtask

   // Locked FFT starves host; host wins as soon as fft_req drops
   task automatic test_contention_locked();
      @(negedge clk);
      fft_lock = 1'b1;
      fft_req = 1'b1; fft_we = 1'b0; fft_addr = 16'h0050;
      host_req = 1'b1; host_we = 1'b0; host_addr = 16'h0051;
      for (int c = 0; c < 20; c++) begin
         #1;
         checks++;
         if (fft_gnt_v !== 3'b111 || host_gnt_v !== 3'b000) begin
            errors++;
            $display("FAIL contention_locked cyc%0d: got fft=%b host=%b, expected 111/000",
                     c, fft_gnt_v, host_gnt_v);
         end
         @(negedge clk);
      end
      fft_req = 1'b0;
      #1;
      checks++;
      if (host_gnt_v !== 3'b111 || fft_gnt_v !== 3'b000) begin
         errors++;
         $display("FAIL locked_release: got fft=%b host=%b, expected 000/111", fft_gnt_v, host_gnt_v);
      end
      @(negedge clk);
      idle_inputs();
      repeat (8) @(negedge clk);
   endtask

   // FFT 0x10, host 0x20, FFT 0x30 on consecutive cycles
   task automatic test_interleaved();
      for (int k = 0; k <= 9; k++) begin
         @(negedge clk);
         fft_req  = (k == 0) || (k == 2);
         host_req = (k == 1);
         fft_we = 1'b0; host_we = 1'b0;
         fft_addr  = (k == 0) ? 16'h0010 : 16'h0030;
         host_addr = 16'h0020;
         #1;
         if (k <= 2) begin
            checks++;
            if (fft_gnt_v !== {3{k != 1}} || host_gnt_v !== {3{k == 1}}) begin
               errors++;
               $display("FAIL interleave_gnt k%0d: got fft=%b host=%b", k, fft_gnt_v, host_gnt_v);
            end
         end
         for (int d = 0; d < NDUT; d++) begin
            int l;
            logic exp_f, exp_h;
            l = lat_of(d);
            exp_f = (k == 2 + l) || (k == 4 + l);
            exp_h = (k == 3 + l);
            checks++;
            if (fft_rvalid_v[d] !== exp_f || host_rvalid_v[d] !== exp_h) begin
               errors++;
               $display("FAIL interleave_rvalid dut%0d k%0d: got fft=%b host=%b, expected fft=%b host=%b",
                        d, k, fft_rvalid_v[d], host_rvalid_v[d], exp_f, exp_h);
            end
            if (k == 2 + l || k == 3 + l) begin
               checks++;
               if (fft_rdata_a[d] !== 32'hC0DE_0010) begin
                  errors++;
                  $display("FAIL interleave_fft_rdata0 dut%0d k%0d: got %h, expected c0de0010",
                           d, k, fft_rdata_a[d]);
               end
            end
            if (k == 3 + l || k == 4 + l) begin
               checks++;
               if (host_rdata_a[d] !== 32'hC0DE_0020) begin
                  errors++;
                  $display("FAIL interleave_host_rdata dut%0d k%0d: got %h, expected c0de0020",
                           d, k, host_rdata_a[d]);
               end
            end
            if (k == 4 + l) begin
               checks++;
               if (fft_rdata_a[d] !== 32'hC0DE_0030) begin
                  errors++;
                  $display("FAIL interleave_fft_rdata1 dut%0d: got %h, expected c0de0030",
                           d, fft_rdata_a[d]);
               end
            end
         end
      end
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_fft_only();
      test_contention_unlocked();
      test_contention_locked();
      test_interleaved();
      repeat (4) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_fft_mem_arb
`default_nettype wire
